// File: rtl/axi_lite_master_arbiter.sv
// axi_lite_master_arbiter: round-robin share of one AXI4-Lite master port among N_REQ requesters
// Ports:
//   i_aclk, i_areset           clock, synchronous active-high reset
//   i_req_valid/write/addr/wdata  per-requester request (packed, requester i at slice i)
//   o_req_ready                one-hot accept pulse
//   o_rsp_valid/rdata/resp     one-hot completion pulse with read data and response code
//   o_m_axi_* / i_m_axi_*      single-beat AXI4-Lite master (AW, W, B, AR, R channels)
module axi_lite_master_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ-1:0]        i_req_write,
    input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [N_REQ*DATA_W-1:0] i_req_wdata,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [N_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]       o_rsp_rdata,
    output logic [1:0]              o_rsp_resp,
    output logic [ADDR_W-1:0]       o_m_axi_awaddr,
    output logic [2:0]              o_m_axi_awprot,
    output logic                    o_m_axi_awvalid,
    input  logic                    i_m_axi_awready,
    output logic [DATA_W-1:0]       o_m_axi_wdata,
    output logic [DATA_W/8-1:0]     o_m_axi_wstrb,
    output logic                    o_m_axi_wvalid,
    input  logic                    i_m_axi_wready,
    input  logic [1:0]              i_m_axi_bresp,
    input  logic                    i_m_axi_bvalid,
    output logic                    o_m_axi_bready,
    output logic [ADDR_W-1:0]       o_m_axi_araddr,
    output logic [2:0]              o_m_axi_arprot,
    output logic                    o_m_axi_arvalid,
    input  logic                    i_m_axi_arready,
    input  logic [DATA_W-1:0]       i_m_axi_rdata,
    input  logic [1:0]              i_m_axi_rresp,
    input  logic                    i_m_axi_rvalid,
    output logic                    o_m_axi_rready
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_gnt;
    logic [IW-1:0]   w_gnt;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_ptr_nxt;
    logic            w_found;
    logic            w_aw_done;
    logic            w_w_done;

    assign o_m_axi_awprot = '0;
    assign o_m_axi_arprot = '0;
    assign o_m_axi_wstrb  = '1;

    // A channel counts as done once its handshake has already happened or happens now.
    assign w_aw_done = !o_m_axi_awvalid || i_m_axi_awready;
    assign w_w_done  = !o_m_axi_wvalid  || i_m_axi_wready;
    assign w_ptr_nxt = (r_gnt == IW'(N_REQ-1)) ? '0 : r_gnt + 1'b1;

    // Descending scan so the candidate closest to r_ptr is the last (winning) assignment.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % N_REQ);
            if (i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_gnt           <= '0;
            o_req_ready     <= '0;
            o_rsp_valid     <= '0;
            o_rsp_rdata     <= '0;
            o_rsp_resp      <= '0;
            o_m_axi_awaddr  <= '0;
            o_m_axi_awvalid <= 1'b0;
            o_m_axi_wdata   <= '0;
            o_m_axi_wvalid  <= 1'b0;
            o_m_axi_bready  <= 1'b0;
            o_m_axi_araddr  <= '0;
            o_m_axi_arvalid <= 1'b0;
            o_m_axi_rready  <= 1'b0;
        end else begin
            o_req_ready <= '0;
            o_rsp_valid <= '0;
            case (r_state)
                S_IDLE: if (w_found) begin
                    o_req_ready <= N_REQ'(1) << w_gnt;
                    r_gnt       <= w_gnt;
                    if (i_req_write[w_gnt]) begin
                        o_m_axi_awaddr  <= i_req_addr[w_gnt*ADDR_W +: ADDR_W];
                        o_m_axi_wdata   <= i_req_wdata[w_gnt*DATA_W +: DATA_W];
                        o_m_axi_awvalid <= 1'b1;
                        o_m_axi_wvalid  <= 1'b1;
                        r_state         <= S_WR;
                    end else begin
                        o_m_axi_araddr  <= i_req_addr[w_gnt*ADDR_W +: ADDR_W];
                        o_m_axi_arvalid <= 1'b1;
                        r_state         <= S_RD_ADDR;
                    end
                end
                S_WR: begin
                    if (i_m_axi_awready) o_m_axi_awvalid <= 1'b0;
                    if (i_m_axi_wready) o_m_axi_wvalid <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        o_m_axi_bready <= 1'b1;
                        r_state        <= S_WR_RESP;
                    end
                end
                S_WR_RESP: if (i_m_axi_bvalid) begin
                    o_m_axi_bready <= 1'b0;
                    o_rsp_valid    <= N_REQ'(1) << r_gnt;
                    o_rsp_resp     <= i_m_axi_bresp;
                    o_rsp_rdata    <= '0;
                    r_ptr          <= w_ptr_nxt;
                    r_state        <= S_IDLE;
                end
                S_RD_ADDR: if (i_m_axi_arready) begin
                    o_m_axi_arvalid <= 1'b0;
                    o_m_axi_rready  <= 1'b1;
                    r_state         <= S_RD_DATA;
                end
                S_RD_DATA: if (i_m_axi_rvalid) begin
                    o_m_axi_rready <= 1'b0;
                    o_rsp_valid    <= N_REQ'(1) << r_gnt;
                    o_rsp_resp     <= i_m_axi_rresp;
                    o_rsp_rdata    <= i_m_axi_rdata;
                    r_ptr          <= w_ptr_nxt;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb_axi_lite_master_arbiter: scoreboard bench with a 4-register AXI4-Lite slave model
module tb_axi_lite_master_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [7:0]  req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_ready, rsp_valid, rsp_resp;
    logic [31:0] rsp_rdata;
    logic [3:0]  awaddr, araddr, wstrb;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, arready;
    logic        bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    logic [31:0] regs [4];
    logic        aw_got, w_got;
    logic [3:0]  aw_a;
    logic [31:0] w_d;
    int          aw_cnt;
    int          b_cnt    = 0;
    int          aw_delay = 0;
    bit          ar_hold  = 1'b0;
    bit          rd_err   = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axi_lite_master_arbiter dut (
        .i_aclk(clk), .i_areset(rst),
        .i_req_valid(req_valid), .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp),
        .o_m_axi_awaddr(awaddr), .o_m_axi_awprot(awprot), .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready),
        .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wvalid(wvalid), .i_m_axi_wready(wready),
        .i_m_axi_bresp(bresp), .i_m_axi_bvalid(bvalid), .o_m_axi_bready(bready),
        .o_m_axi_araddr(araddr), .o_m_axi_arprot(arprot), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready),
        .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready)
    );

    // Slave: AWREADY after aw_delay waiting cycles, WREADY immediate, B one cycle after both land.
    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid;
    assign arready = arvalid && !ar_hold;

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            aw_a   <= '0;
            w_d    <= '0;
            aw_cnt <= 0;
            bvalid <= 1'b0;
            bresp  <= '0;
            rvalid <= 1'b0;
            rresp  <= '0;
            rdata  <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            if (awvalid && awready) begin
                aw_got <= 1'b1;
                aw_a   <= awaddr;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1;
                w_d   <= wdata;
            end
            if (aw_got && w_got && !bvalid) begin
                regs[aw_a[3:2]] <= w_d;
                bvalid <= 1'b1;
                bresp  <= 2'b00;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                b_cnt  <= b_cnt + 1;
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= regs[araddr[3:2]];
                rresp  <= (rd_err && araddr == 4'h8) ? 2'b10 : 2'b00;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    task automatic push(input int id, input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        e.id = id;
        e.data = d;
        e.resp = r;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic issue(input int i, input bit wr, input logic [3:0] a, input logic [31:0] d, output int waited);
        int k;
        logic [1:0] want;
        k = 0;
        want = 2'b01 << i;
        req_write[i] = wr;
        req_addr[i*4 +: 4] = a;
        req_wdata[i*32 +: 32] = d;
        req_valid[i] = 1'b1;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!req_ready[i] && k < 200);
        req_valid[i] = 1'b0;
        waited = k;
        n_vec++;
        if (req_ready !== want) begin
            n_err++;
            $display("FAIL grant_req%0d: req_ready=%b required %b", i, req_ready, want);
        end
    endtask

    task automatic collect(input int n);
        for (int j = 0; j < n; j++) begin
            int k;
            exp_t e;
            k = 0;
            do begin
                @(posedge clk); #1;
                k++;
            end while (rsp_valid == 2'b00 && k < 400);
            n_vec++;
            if (rsp_valid == 2'b00) begin
                n_err++;
                $display("FAIL rsp_timeout: rsp_valid=%b required a pulse", rsp_valid);
            end else if (sb.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: rsp_valid=%b required none", rsp_valid);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== (2'b01 << e.id) || rsp_rdata !== e.data || rsp_resp !== e.resp) begin
                    n_err++;
                    $display("FAIL rsp: valid=%b rdata=%h resp=%b required valid=%b rdata=%h resp=%b",
                             rsp_valid, rsp_rdata, rsp_resp, 2'b01 << e.id, e.data, e.resp);
                end
            end
        end
    endtask

    task automatic test_reset();
        int w0, w1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req_valid = 2'($urandom);
            req_write = 2'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = {$urandom, $urandom};
        end
        n_vec++;
        if ({req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: ready=%b rsp=%b aw/w/b/ar/r=%b%b%b%b%b required all 0",
                     req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready);
        end
        n_vec++;
        if (rsp_rdata !== 0 || rsp_resp !== 0 || awaddr !== 0 || araddr !== 0 || wdata !== 0) begin
            n_err++;
            $display("FAIL reset_data: rdata=%h resp=%b awaddr=%h araddr=%h wdata=%h required 0",
                     rsp_rdata, rsp_resp, awaddr, araddr, wdata);
        end
        n_vec++;
        if (wstrb !== 4'hF || awprot !== 3'b000 || arprot !== 3'b000) begin
            n_err++;
            $display("FAIL reset_const: wstrb=%h awprot=%b arprot=%b required f 000 000", wstrb, awprot, arprot);
        end
        req_valid = '0;
        rst = 1'b0;
        sb.delete();
        push(0, 32'h0, 2'b00);
        push(1, 32'h0, 2'b00);
        fork
            issue(0, 1'b0, 4'h0, 32'h0, w0);
            issue(1, 1'b0, 4'h0, 32'h0, w1);
            collect(2);
        join
    endtask

    task automatic test_single();
        int w;
        do_reset();
        push(0, 32'h0, 2'b00);
        issue(0, 1'b1, 4'h4, 32'hDEAD_BEEF, w);
        n_vec++;
        if (awvalid !== 1'b1 || awaddr !== 4'h4 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin
            n_err++;
            $display("FAIL write_bus: awvalid=%b awaddr=%h wdata=%h wstrb=%h required 1 4 deadbeef f",
                     awvalid, awaddr, wdata, wstrb);
        end
        collect(1);
        push(0, 32'hDEAD_BEEF, 2'b00);
        issue(0, 1'b0, 4'h4, 32'h0, w);
        collect(1);
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        for (int j = 0; j < 8; j++) push(j % 2, 32'h0, 2'b00);
        fork
            begin
                int w0;
                for (int j = 0; j < 4; j++) issue(0, 1'b1, 4'(j*4), 32'hA000_0000 | j, w0);
            end
            begin
                int w1;
                for (int j = 0; j < 4; j++) issue(1, 1'b1, 4'(j*4), 32'hB000_0000 | j, w1);
            end
            collect(8);
        join
        for (int j = 0; j < 4; j++) begin
            push(0, 32'hB000_0000 | j, 2'b00);
            issue(0, 1'b0, 4'(j*4), 32'h0, w);
            collect(1);
        end
    endtask

    task automatic test_aw_delay();
        int w, aw_n, w_n, b0, k;
        exp_t e;
        do_reset();
        aw_delay = 3;
        aw_n = 0;
        w_n = 0;
        k = 0;
        b0 = b_cnt;
        push(0, 32'h0, 2'b00);
        issue(0, 1'b1, 4'h8, 32'h1234_5678, w);
        while (rsp_valid == 2'b00 && k < 50) begin
            aw_n += int'(awvalid);
            w_n += int'(wvalid);
            @(posedge clk); #1;
            k++;
        end
        n_vec++;
        if (aw_n !== 4 || w_n !== 1) begin
            n_err++;
            $display("FAIL aw_delay_cycles: awvalid=%0d wvalid=%0d cycles required 4 1", aw_n, w_n);
        end
        n_vec++;
        if (rsp_valid == 2'b00 || sb.size() == 0) begin
            n_err++;
            $display("FAIL aw_delay_rsp: rsp_valid=%b required 01", rsp_valid);
        end else begin
            e = sb.pop_front();
            if (rsp_valid !== (2'b01 << e.id) || rsp_rdata !== e.data || rsp_resp !== e.resp) begin
                n_err++;
                $display("FAIL aw_delay_rsp: valid=%b rdata=%h resp=%b required %b %h %b",
                         rsp_valid, rsp_rdata, rsp_resp, 2'b01 << e.id, e.data, e.resp);
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        n_vec++;
        if (b_cnt - b0 !== 1) begin
            n_err++;
            $display("FAIL b_handshakes: count=%0d required 1", b_cnt - b0);
        end
        aw_delay = 0;
    endtask

    task automatic test_rd_error();
        int w;
        do_reset();
        push(0, 32'h0, 2'b00);
        issue(0, 1'b1, 4'h8, 32'hCAFE_F00D, w);
        collect(1);
        rd_err = 1'b1;
        push(0, 32'hCAFE_F00D, 2'b10);
        issue(0, 1'b0, 4'h8, 32'h0, w);
        collect(1);
        rd_err = 1'b0;
        push(1, 32'h0, 2'b00);
        issue(1, 1'b1, 4'h0, 32'h5555_AAAA, w);
        n_vec++;
        if (w !== 1) begin
            n_err++;
            $display("FAIL idle_after_err: grant wait=%0d cycles required 1", w);
        end
        collect(1);
    endtask

    task automatic test_reset_mid();
        int w, w0, w1;
        logic [1:0] seen;
        do_reset();
        push(0, 32'h0, 2'b00);
        issue(0, 1'b0, 4'h0, 32'h0, w);
        collect(1);
        ar_hold = 1'b1;
        issue(1, 1'b0, 4'h4, 32'h0, w);
        repeat (2) begin @(posedge clk); #1; end
        n_vec++;
        if (arvalid !== 1'b1) begin
            n_err++;
            $display("FAIL ar_hold: arvalid=%b required 1", arvalid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL mid_reset: arvalid=%b rready=%b rsp=%b ready=%b required 0 0 00 00",
                     arvalid, rready, rsp_valid, req_ready);
        end
        rst = 1'b0;
        ar_hold = 1'b0;
        seen = '0;
        repeat (5) begin
            @(posedge clk); #1;
            seen |= rsp_valid;
        end
        n_vec++;
        if (seen !== 2'b00) begin
            n_err++;
            $display("FAIL rsp_after_reset: rsp_valid seen=%b required 00", seen);
        end
        push(0, 32'h0, 2'b00);
        push(1, 32'h0, 2'b00);
        fork
            issue(0, 1'b0, 4'h0, 32'h0, w0);
            issue(1, 1'b0, 4'h4, 32'h0, w1);
            collect(2);
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_aw_delay();
        test_rd_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
